// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: central sequencer for the 5-stage pipeline.
// Turns hazard, branch, mem-busy and halt events into per-stage
// write-enable / flush / bubble controls. Runs the
// IDLE -> RUN <-> FREEZE -> DRAIN -> DONE lifecycle.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   start_i, load_use_i, branch_taken_i, mem_busy_i, halt_i
//   pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o,
//   exmem_we_o, memwb_we_o (combinational, same-edge)
//   state_o, stall_cnt_o, flush_cnt_o, timeout_err_o, done_o
// Macro PIPE_SEQ_CTRL_PERF_CNT_EN: when defined, the saturating
// stall/flush counters exist; otherwise both outputs read 0.
module pipe_seq_ctrl #(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 3,
  parameter int FREEZE_MAX   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  input  logic             halt_i,
  output logic             pc_we_o,
  output logic             ifid_we_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             exmem_we_o,
  output logic             memwb_we_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             timeout_err_o,
  output logic             done_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_FREEZE = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int FRZ_W = (FREEZE_MAX < 1) ? 1
                       : $clog2(FREEZE_MAX + 1);
  localparam int DRN_W = (DRAIN_CYCLES < 1) ? 1
                       : $clog2(DRAIN_CYCLES + 1);

  localparam logic [FRZ_W-1:0] FRZ_MAX = FRZ_W'(FREEZE_MAX);
  localparam logic [DRN_W-1:0] DRN_INI = DRN_W'(DRAIN_CYCLES);

  logic [2:0]       state_q, state_d;
  logic [FRZ_W-1:0] frz_q, frz_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic             tmo_q, tmo_d;
  logic             done_q, done_d;
  logic             run_rules;
  logic             stall_inc;
  logic             flush_inc;

  always_comb begin
    state_d       = state_q;
    frz_d         = frz_q;
    drn_d         = drn_q;
    tmo_d         = tmo_q;
    run_rules     = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    pc_we_o       = 1'b0;
    ifid_we_o     = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    exmem_we_o    = 1'b0;
    memwb_we_o    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (mem_busy_i) begin
          state_d = S_FREEZE;
          frz_d   = FRZ_W'(1);
        end else begin
          run_rules = 1'b1;
        end
      end
      S_FREEZE: begin
        if (mem_busy_i) begin
          if (frz_q != FRZ_MAX) frz_d = frz_q + FRZ_W'(1);
        end else begin
          frz_d     = '0;
          state_d   = S_RUN;
          run_rules = 1'b1;
        end
      end
      S_DRAIN: begin
        // A busy memory freezes the drain and holds the count.
        if (!mem_busy_i) begin
          idex_bubble_o = 1'b1;
          exmem_we_o    = 1'b1;
          memwb_we_o    = 1'b1;
          drn_d         = drn_q - DRN_W'(1);
          if (drn_q <= DRN_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Shared by RUN and the release cycle of FREEZE.
    if (run_rules) begin
      exmem_we_o = 1'b1;
      memwb_we_o = 1'b1;
      if (load_use_i) begin
        idex_bubble_o = 1'b1;
        stall_inc     = 1'b1;
      end else if (branch_taken_i) begin
        pc_we_o      = 1'b1;
        ifid_we_o    = 1'b1;
        ifid_flush_o = 1'b1;
        flush_inc    = 1'b1;
      end else if (halt_i) begin
        drn_d   = DRN_INI;
        state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
      end else begin
        pc_we_o   = 1'b1;
        ifid_we_o = 1'b1;
      end
    end

    if (frz_d == FRZ_MAX) tmo_d = 1'b1;
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      frz_q   <= '0;
      drn_q   <= '0;
      tmo_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frz_q   <= frz_d;
      drn_q   <= drn_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
    end
  end

`ifdef PIPE_SEQ_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturate at all-ones rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_inc && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = stall_inc ^ flush_inc;
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

  assign state_o       = state_q;
  assign timeout_err_o = tmo_q;
  assign done_o        = done_q;

endmodule
